// File: rtl/iob_iob2axil_ot.sv
// IOb native to AXI4-Lite bridge with bounded outstanding reads and write responses.
// Reads and writes are mutually ordered: neither kind issues while the other is in flight.
module iob_iob2axil_ot #(
    parameter int unsigned AXIL_ADDR_W = 21,
    parameter int unsigned AXIL_DATA_W = 32,
    parameter int unsigned ADDR_W      = AXIL_ADDR_W,
    parameter int unsigned DATA_W      = AXIL_DATA_W,
    parameter int unsigned MAX_OUTST   = 4
) (
    input  logic                     clk_i,
    input  logic                     cke_i,
    input  logic                     arst_i,

    input  logic                     iob_valid_i,
    input  logic [ADDR_W-1:0]        iob_addr_i,
    input  logic [DATA_W-1:0]        iob_wdata_i,
    input  logic [DATA_W/8-1:0]      iob_wstrb_i,
    output logic                     iob_ready_o,
    output logic                     iob_rvalid_o,
    output logic [DATA_W-1:0]        iob_rdata_o,
    input  logic                     iob_rready_i,

    output logic                     axil_awvalid_o,
    input  logic                     axil_awready_i,
    output logic [AXIL_ADDR_W-1:0]   axil_awaddr_o,
    output logic [2:0]               axil_awprot_o,
    output logic                     axil_wvalid_o,
    input  logic                     axil_wready_i,
    output logic [AXIL_DATA_W-1:0]   axil_wdata_o,
    output logic [AXIL_DATA_W/8-1:0] axil_wstrb_o,
    input  logic                     axil_bvalid_i,
    output logic                     axil_bready_o,
    input  logic [1:0]               axil_bresp_i,
    output logic                     axil_arvalid_o,
    input  logic                     axil_arready_i,
    output logic [AXIL_ADDR_W-1:0]   axil_araddr_o,
    output logic [2:0]               axil_arprot_o,
    input  logic                     axil_rvalid_i,
    output logic                     axil_rready_o,
    input  logic [AXIL_DATA_W-1:0]   axil_rdata_i,
    input  logic [1:0]               axil_rresp_i,

    output logic                     err_o,
    input  logic                     err_clr_i
);

    localparam int unsigned      CNT_W   = $clog2(MAX_OUTST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTST);

    typedef enum logic {IDLE, WR_ADDR_DATA} wr_state_t;

    wr_state_t        state_q, state_d;
    logic             aw_done_q, aw_done_d;
    logic             w_done_q, w_done_d;
    logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
    logic             err_q, err_d;

    logic wr_req, aw_hs, w_hs, b_hs, ar_hs, r_hs, wr_done;

    // Address, data and read-return paths are straight wires
    assign axil_awaddr_o = iob_addr_i;
    assign axil_araddr_o = iob_addr_i;
    assign axil_wdata_o  = iob_wdata_i;
    assign axil_wstrb_o  = iob_wstrb_i;
    assign axil_awprot_o = 3'd2;
    assign axil_arprot_o = 3'd2;
    assign iob_rvalid_o  = axil_rvalid_i;
    assign iob_rdata_o   = axil_rdata_i;
    assign axil_rready_o = iob_rready_i;

    assign wr_req         = iob_valid_i & (|iob_wstrb_i);
    assign axil_awvalid_o = (state_q == WR_ADDR_DATA) & ~aw_done_q;
    assign axil_wvalid_o  = (state_q == WR_ADDR_DATA) & ~w_done_q;
    assign axil_bready_o  = (wr_cnt_q != '0);
    assign axil_arvalid_o = iob_valid_i & ~(|iob_wstrb_i) & (wr_cnt_q == '0)
                          & (state_q == IDLE) & (rd_cnt_q < CNT_MAX);

    assign aw_hs = axil_awvalid_o & axil_awready_i;
    assign w_hs  = axil_wvalid_o & axil_wready_i;
    assign b_hs  = axil_bvalid_i & axil_bready_o;
    assign ar_hs = axil_arvalid_o & axil_arready_i;
    assign r_hs  = axil_rvalid_i & axil_rready_o;

    assign wr_done     = (state_q == WR_ADDR_DATA) & (aw_done_q | aw_hs) & (w_done_q | w_hs);
    assign iob_ready_o = wr_done | ar_hs;
    assign err_o       = err_q;

    always_comb begin
        state_d   = state_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        wr_cnt_d  = wr_cnt_q;
        rd_cnt_d  = rd_cnt_q;
        err_d     = err_q;

        case (state_q)
            IDLE: begin
                if (wr_req && (rd_cnt_q == '0) && (wr_cnt_q < CNT_MAX)) begin
                    state_d = WR_ADDR_DATA;
                end
            end
            WR_ADDR_DATA: begin
                if (wr_done) begin
                    state_d   = IDLE;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end else begin
                    aw_done_d = aw_done_q | aw_hs;
                    w_done_d  = w_done_q | w_hs;
                end
            end
            default: state_d = IDLE;
        endcase

        // Simultaneous issue and retire leaves a counter unchanged; empty counters never decrement
        if (wr_done && !b_hs) begin
            wr_cnt_d = wr_cnt_q + CNT_W'(1);
        end else if (b_hs && !wr_done && (wr_cnt_q != '0)) begin
            wr_cnt_d = wr_cnt_q - CNT_W'(1);
        end

        if (ar_hs && !r_hs) begin
            rd_cnt_d = rd_cnt_q + CNT_W'(1);
        end else if (r_hs && !ar_hs && (rd_cnt_q != '0)) begin
            rd_cnt_d = rd_cnt_q - CNT_W'(1);
        end

        if ((b_hs && (axil_bresp_i != 2'b00)) || (r_hs && (axil_rresp_i != 2'b00))) begin
            err_d = 1'b1;
        end else if (err_clr_i) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q   <= IDLE;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            err_q     <= 1'b0;
        end else if (cke_i) begin
            state_q   <= state_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_iob_iob2axil_ot.sv
// Bench for iob_iob2axil_ot: directed scenarios then random traffic against a transaction-level model.
module tb_iob_iob2axil_ot;

    localparam int AW = 21;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int MAXO = 4;

    logic          clk_i = 1'b0;
    logic          cke_i, arst_i;
    logic          iob_valid_i, iob_ready_o, iob_rvalid_o, iob_rready_i;
    logic [AW-1:0] iob_addr_i;
    logic [DW-1:0] iob_wdata_i, iob_rdata_o;
    logic [SW-1:0] iob_wstrb_i;
    logic          axil_awvalid_o, axil_awready_i, axil_wvalid_o, axil_wready_i;
    logic [AW-1:0] axil_awaddr_o, axil_araddr_o;
    logic [2:0]    axil_awprot_o, axil_arprot_o;
    logic [DW-1:0] axil_wdata_o, axil_rdata_i;
    logic [SW-1:0] axil_wstrb_o;
    logic          axil_bvalid_i, axil_bready_o, axil_arvalid_o, axil_arready_i;
    logic          axil_rvalid_i, axil_rready_o;
    logic [1:0]    axil_bresp_i, axil_rresp_i;
    logic          err_o, err_clr_i;

    int checks = 0;
    int failures = 0;

    // Model: outstanding counts, one pending write with its address/data progress, sticky error
    int m_wr_out, m_rd_out;
    bit m_busy, m_aw_seen, m_w_seen, m_err;
    bit e_aw, e_w, e_ar, e_bready, e_fin, e_ready;
    bit c_aw_hs, c_w_hs, c_ar_hs, c_b_hs, c_r_hs, c_is_wr;

    iob_iob2axil_ot #(.AXIL_ADDR_W(AW), .AXIL_DATA_W(DW), .MAX_OUTST(MAXO)) dut (
        .clk_i(clk_i), .cke_i(cke_i), .arst_i(arst_i),
        .iob_valid_i(iob_valid_i), .iob_addr_i(iob_addr_i), .iob_wdata_i(iob_wdata_i),
        .iob_wstrb_i(iob_wstrb_i), .iob_ready_o(iob_ready_o), .iob_rvalid_o(iob_rvalid_o),
        .iob_rdata_o(iob_rdata_o), .iob_rready_i(iob_rready_i),
        .axil_awvalid_o(axil_awvalid_o), .axil_awready_i(axil_awready_i),
        .axil_awaddr_o(axil_awaddr_o), .axil_awprot_o(axil_awprot_o),
        .axil_wvalid_o(axil_wvalid_o), .axil_wready_i(axil_wready_i),
        .axil_wdata_o(axil_wdata_o), .axil_wstrb_o(axil_wstrb_o),
        .axil_bvalid_i(axil_bvalid_i), .axil_bready_o(axil_bready_o), .axil_bresp_i(axil_bresp_i),
        .axil_arvalid_o(axil_arvalid_o), .axil_arready_i(axil_arready_i),
        .axil_araddr_o(axil_araddr_o), .axil_arprot_o(axil_arprot_o),
        .axil_rvalid_i(axil_rvalid_i), .axil_rready_o(axil_rready_o),
        .axil_rdata_i(axil_rdata_i), .axil_rresp_i(axil_rresp_i),
        .err_o(err_o), .err_clr_i(err_clr_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_wr_out = 0; m_rd_out = 0; m_busy = 0; m_aw_seen = 0; m_w_seen = 0; m_err = 0;
    endtask

    // Predict this cycle's outputs from the model and the driven inputs, then compare
    task automatic check();
        c_is_wr  = iob_valid_i && (iob_wstrb_i != '0);
        e_aw     = m_busy && !m_aw_seen;
        e_w      = m_busy && !m_w_seen;
        e_ar     = iob_valid_i && !c_is_wr && !m_busy && (m_wr_out == 0) && (m_rd_out < MAXO);
        e_bready = (m_wr_out > 0);
        c_aw_hs  = e_aw && axil_awready_i;
        c_w_hs   = e_w && axil_wready_i;
        c_ar_hs  = e_ar && axil_arready_i;
        c_b_hs   = e_bready && axil_bvalid_i;
        c_r_hs   = axil_rvalid_i && iob_rready_i;
        e_fin    = m_busy && (m_aw_seen || c_aw_hs) && (m_w_seen || c_w_hs);
        e_ready  = e_fin || c_ar_hs;
        chk("awvalid", axil_awvalid_o, e_aw);
        chk("wvalid", axil_wvalid_o, e_w);
        chk("arvalid", axil_arvalid_o, e_ar);
        chk("bready", axil_bready_o, e_bready);
        chk("iob_ready", iob_ready_o, e_ready);
        chk("err", err_o, m_err);
        chk("awaddr", axil_awaddr_o, iob_addr_i);
        chk("araddr", axil_araddr_o, iob_addr_i);
        chk("wdata", axil_wdata_o, iob_wdata_i);
        chk("wstrb", axil_wstrb_o, iob_wstrb_i);
        chk("prot", {axil_awprot_o, axil_arprot_o}, 6'o22);
        chk("rpass", {iob_rvalid_o, axil_rready_o, iob_rdata_o},
            {axil_rvalid_i, iob_rready_i, axil_rdata_i});
    endtask

    task automatic update();
        if (e_fin) begin
            m_busy = 0; m_aw_seen = 0; m_w_seen = 0;
        end else if (m_busy) begin
            m_aw_seen = m_aw_seen || c_aw_hs;
            m_w_seen  = m_w_seen || c_w_hs;
        end else if (c_is_wr && m_rd_out == 0 && m_wr_out < MAXO) begin
            m_busy = 1;
        end
        if ((c_b_hs && axil_bresp_i != 0) || (c_r_hs && axil_rresp_i != 0)) m_err = 1;
        else if (err_clr_i) m_err = 0;
        m_wr_out = m_wr_out + (e_fin ? 1 : 0) - (c_b_hs ? 1 : 0);
        m_rd_out = m_rd_out + (c_ar_hs ? 1 : 0) - ((c_r_hs && m_rd_out > 0) ? 1 : 0);
    endtask

    // Called just after a negedge with inputs set; returns at the next negedge
    task automatic cycle();
        #1 check();
        @(posedge clk_i);
        update();
        @(negedge clk_i);
    endtask

    task automatic set_req(input bit v, input bit wr);
        iob_valid_i = v;
        iob_addr_i  = AW'($urandom);
        iob_wdata_i = $urandom;
        iob_wstrb_i = wr ? SW'($urandom_range(1, 15)) : '0;
    endtask

    bit req_on;

    initial begin
        cke_i = 1; arst_i = 1; err_clr_i = 0; iob_rready_i = 1;
        set_req(0, 0);
        axil_awready_i = 0; axil_wready_i = 0; axil_arready_i = 0;
        axil_bvalid_i = 0; axil_bresp_i = 0; axil_rvalid_i = 0; axil_rresp_i = 0; axil_rdata_i = '0;
        model_reset();
        @(negedge clk_i);
        #1 check();
        @(negedge clk_i);
        arst_i = 0;

        // Write with AW accepted before W; response drains the counter
        set_req(1, 1);
        cycle();
        axil_awready_i = 1;
        #1 chk("w1_ready_after_aw", iob_ready_o, 0);
        cycle();
        axil_awready_i = 0;
        #1 chk("w1_aw_dropped", axil_awvalid_o, 0);
        cycle();
        axil_wready_i = 1;
        #1 chk("w1_ready_at_w", iob_ready_o, 1);
        cycle();
        set_req(0, 0); axil_wready_i = 0;
        #1 chk("w1_bready", axil_bready_o, 1);
        cycle();
        axil_bvalid_i = 1;
        cycle();
        axil_bvalid_i = 0;
        #1 chk("w1_bready_clear", {axil_bready_o, err_o}, 2'b00);
        cycle();

        // Five reads against four slots; the fifth waits for one R beat
        set_req(1, 0); axil_arready_i = 1;
        for (int i = 0; i < MAXO; i++) begin
            #1 chk("rd_issue", axil_arvalid_o, 1);
            cycle();
        end
        #1 chk("rd_stall", {axil_arvalid_o, iob_ready_o}, 2'b00);
        cycle();
        axil_rvalid_i = 1; axil_rdata_i = $urandom;
        #1 chk("rd_stall_beat", axil_arvalid_o, 0);
        cycle();
        axil_rvalid_i = 0;
        #1 chk("rd_fifth", axil_arvalid_o, 1);
        cycle();
        set_req(0, 0);
        axil_rvalid_i = 1;
        repeat (MAXO) cycle();
        axil_rvalid_i = 0;

        // Write held off by an outstanding read
        set_req(1, 0);
        cycle();
        set_req(1, 1); axil_awready_i = 1; axil_wready_i = 1;
        repeat (2) begin
            #1 chk("wr_blocked", {axil_awvalid_o, axil_wvalid_o}, 2'b00);
            cycle();
        end
        axil_rvalid_i = 1;
        cycle();
        axil_rvalid_i = 0;
        cycle();
        #1 chk("wr_after_read", {axil_awvalid_o, axil_wvalid_o, iob_ready_o}, 3'b111);
        cycle();
        set_req(0, 0); axil_bvalid_i = 1;
        cycle();
        axil_bvalid_i = 0;

        // Sticky error: set, clear, and set winning over clear
        set_req(1, 0);
        cycle();
        set_req(0, 0); axil_rvalid_i = 1; axil_rresp_i = 2'b10;
        cycle();
        axil_rvalid_i = 0; axil_rresp_i = 0;
        #1 chk("err_set", err_o, 1);
        err_clr_i = 1;
        cycle();
        err_clr_i = 0;
        #1 chk("err_cleared", err_o, 0);
        set_req(1, 0);
        cycle();
        set_req(0, 0); axil_rvalid_i = 1; axil_rresp_i = 2'b11; err_clr_i = 1;
        cycle();
        axil_rvalid_i = 0; axil_rresp_i = 0; err_clr_i = 0;
        #1 chk("err_set_over_clr", err_o, 1);
        err_clr_i = 1;
        cycle();
        err_clr_i = 0;

        // Same-cycle AR and R at two outstanding leaves two outstanding
        set_req(1, 0);
        cycle(); cycle();
        axil_rvalid_i = 1;
        cycle();
        set_req(1, 1);
        cycle(); cycle();
        axil_rvalid_i = 0;
        #1 chk("rd2_third_beat_needed", axil_awvalid_o, 0);
        cycle();
        #1 chk("rd2_write_starts", axil_awvalid_o, 1);
        cycle();
        set_req(1, 1);
        cycle();
        axil_awready_i = 0; axil_wready_i = 0;
        cycle();

        // Asynchronous reset mid-write with one response still owed
        #2 arst_i = 1;
        #1 chk("rst_outputs", {axil_awvalid_o, axil_wvalid_o, axil_arvalid_o, axil_bready_o, iob_ready_o, err_o}, 6'b0);
        model_reset();
        set_req(1, 0);
        @(negedge clk_i);
        arst_i = 0;
        #1 chk("rst_counters_cleared", axil_arvalid_o, 1);
        cycle();
        set_req(0, 0); axil_rvalid_i = 1;
        cycle();
        axil_rvalid_i = 0;

        // Random traffic
        req_on = 0;
        for (int n = 0; n < 3000; n++) begin
            if (!req_on && $urandom_range(0, 2) == 0) begin
                req_on = 1;
                set_req(1, $urandom_range(0, 1) == 1);
            end
            axil_awready_i = $urandom_range(0, 1) == 1;
            axil_wready_i  = $urandom_range(0, 1) == 1;
            axil_arready_i = $urandom_range(0, 1) == 1;
            axil_bvalid_i  = (m_wr_out > 0) && ($urandom_range(0, 2) == 0);
            axil_bresp_i   = ($urandom_range(0, 15) == 0) ? 2'b10 : 2'b00;
            axil_rvalid_i  = (m_rd_out > 0) && ($urandom_range(0, 2) == 0);
            axil_rresp_i   = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'b00;
            axil_rdata_i   = $urandom;
            iob_rready_i   = $urandom_range(0, 3) != 0;
            err_clr_i      = $urandom_range(0, 9) == 0;
            cycle();
            if (e_ready) begin
                req_on = 0;
                set_req(0, 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/iob_iob2axil_ot.md
IOB_IOB2AXIL_OT -- requirements
Module: iob_iob2axil_ot

Interface
- REQ-001: Parameter AXIL_ADDR_W, default 21, AXI4-Lite address width in bits; SHALL be 1..64.
- REQ-002: Parameter AXIL_DATA_W, default 32, AXI4-Lite data width in bits; SHALL be a multiple of 8.
- REQ-003: Parameter ADDR_W, default AXIL_ADDR_W, IOb address width; SHALL equal AXIL_ADDR_W.
- REQ-004: Parameter DATA_W, default AXIL_DATA_W, IOb data width; SHALL equal AXIL_DATA_W.
- REQ-005: Parameter MAX_OUTST, default 4, maximum outstanding reads and maximum outstanding write responses; SHALL be 1..16.
- REQ-006: Counters SHALL be CNT_W = $clog2(MAX_OUTST+1) bits wide.
- REQ-007: Clocking and reset: one clock, clk_i; reset arst_i is asynchronous and active-high; cke_i gates all register updates.
- REQ-008: clk_i  in  1  clock.
- REQ-009: cke_i  in  1  clock enable.
- REQ-010: arst_i  in  1  async active-high reset.
- REQ-011: iob_valid_i  in  1; iob_addr_i  in  ADDR_W; iob_wdata_i  in  DATA_W; iob_wstrb_i  in  DATA_W/8 (nonzero = write).
- REQ-012: iob_ready_o  out  1; iob_rvalid_o  out  1; iob_rdata_o  out  DATA_W; iob_rready_i  in  1.
- REQ-013: axil_aw{valid_o,ready_i,addr_o[AXIL_ADDR_W],prot_o[3]}, axil_w{valid_o,ready_i,data_o[AXIL_DATA_W],strb_o[AXIL_DATA_W/8]}, axil_b{valid_i,ready_o,resp_i[2]}, axil_ar{valid_o,ready_i,addr_o,prot_o[3]}, axil_r{valid_i,ready_o,data_i,resp_i[2]}, with standard AXI4-Lite meanings.
- REQ-014: err_o  out  1  sticky error flag (non-OKAY BRESP or RRESP seen).
- REQ-015: err_clr_i  in  1  synchronous clear of err_o.

Function
- REQ-016: awprot_o and arprot_o SHALL be constant 3'd2; awaddr_o/araddr_o SHALL be iob_addr_i; wdata_o/wstrb_o SHALL be iob_wdata_i/iob_wstrb_i.
- REQ-017: Write FSM states: IDLE, WR_ADDR_DATA. IDLE->WR_ADDR_DATA when iob_valid_i & |iob_wstrb_i & rd_cnt==0 & wr_cnt<MAX_OUTST.
- REQ-018: In WR_ADDR_DATA, awvalid_o SHALL be 1 until AW handshake, wvalid_o SHALL be 1 until W handshake; each tracked by its own done flag, so AW and W may complete in either order or the same cycle.
- REQ-019: iob_ready_o for a write SHALL pulse 1 for exactly one cycle, in the cycle in which the later of the AW/W handshakes occurs; FSM SHALL then return to IDLE and clear both done flags.
- REQ-020: wr_cnt SHALL increment on write completion (REQ-019), decrement on bvalid_i & bready_o, and stay unchanged when both occur in the same cycle.
- REQ-021: bready_o SHALL be 1 whenever wr_cnt>0, else 0.
- REQ-022: Reads: arvalid_o = iob_valid_i & ~|iob_wstrb_i & wr_cnt==0 & state==IDLE & rd_cnt<MAX_OUTST; iob_ready_o for a read = arvalid_o & arready_i (zero added latency).
- REQ-023: rd_cnt SHALL increment on AR handshake, decrement on rvalid_i & rready_o, and stay unchanged when both occur in the same cycle.
- REQ-024: iob_rvalid_o = rvalid_i; iob_rdata_o = rdata_i; rready_o = iob_rready_i.
- REQ-025: Ordering: no read issued while any write is in WR_ADDR_DATA or unacknowledged (wr_cnt>0); no write started while rd_cnt>0.
- REQ-026: At counter==MAX_OUTST, new requests of that kind SHALL stall (iob_ready_o=0, no AXI valid) until a response drains the counter; counters SHALL never wrap.
- REQ-027: err_o SHALL set on (bvalid_i & bready_o & bresp_i!=0) or (rvalid_i & rready_o & rresp_i!=0); err_clr_i SHALL clear it, with set taking priority when both occur in the same cycle.

Reset
- REQ-028: On arst_i=1, immediately: state=IDLE, done flags=0, wr_cnt=rd_cnt=0, err_o=0, hence awvalid_o=wvalid_o=arvalid_o=bready_o=iob_ready_o=0.
- REQ-029: Reset mid-transaction SHALL abandon in-flight transfers without generating an iob_ready_o pulse.

Verification
- REQ-030: Write, AW ready at cycle 1, W ready at cycle 3 -> awvalid_o drops after cycle 1; iob_ready_o=1 only at cycle 3; wr_cnt=1 until bvalid_i with bresp_i=0 -> wr_cnt=0, err_o=0.
- REQ-031: MAX_OUTST=4, arready_i=1, rvalid_i held 0, 5 back-to-back reads -> 4 AR handshakes; 5th stalls with arvalid_o=0 until one R beat, then issues.
- REQ-032: Read outstanding (rd_cnt=1) and a write request -> awvalid_o=wvalid_o=0 until R beat; after it, write proceeds.
- REQ-033: rresp_i=2'b10 on an R beat -> err_o=1 next cycle; err_clr_i pulse -> err_o=0; simultaneous error and clear -> err_o stays 1.
- REQ-034: Same-cycle AR handshake and R beat at rd_cnt=2 -> rd_cnt stays 2.
- REQ-035: arst_i asserted mid-write with awvalid_o=1 -> all valids 0 asynchronously; counters 0; no iob_ready_o pulse.
